// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID at word 0, build timestamp at word 1),
// compares both words against build-time constants and publishes sticky pass/fail flags.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1579770612,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_LAT_ID,
      S_RD_TS,
      S_LAT_TS,
      S_DONE
   } state_e;

   localparam logic [2:0]  LAT_LAST    = (READ_LATENCY == 0) ? 3'd0 : 3'(READ_LATENCY - 1);
   localparam logic [16:0] STALL_LIMIT = 17'(TIMEOUT_CYCLES);

   state_e      state_q, state_d;
   logic        auto_pend_q, auto_pend_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [2:0]  lat_cnt_q, lat_cnt_d;
   logic        avm_read_q, avm_read_d;
   logic        avm_address_q, avm_address_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        pass_q, pass_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;

   logic stall_expired;
   logic lat_last;
   logic capture_id;
   logic capture_ts;
   logic abort;

   // The stall that would make the count reach the limit ends the access instead of counting.
   assign stall_expired = avm_waitrequest && (({1'b0, stall_cnt_q} + 17'd1) == STALL_LIMIT);
   assign lat_last      = (lat_cnt_q == LAT_LAST);

   always_comb begin
      // NOTE: every _d starts as its _q so no branch of the case below can infer a latch.
      state_d       = state_q;
      auto_pend_d   = auto_pend_q;
      stall_cnt_d   = stall_cnt_q;
      lat_cnt_d     = lat_cnt_q;
      avm_read_d    = avm_read_q;
      avm_address_d = avm_address_q;
      busy_d        = busy_q;
      done_d        = done_q;
      id_ok_d       = id_ok_q;
      ts_ok_d       = ts_ok_q;
      pass_d        = pass_q;
      timeout_d     = timeout_q;
      id_value_d    = id_value_q;
      ts_value_d    = ts_value_q;
      capture_id    = 1'b0;
      capture_ts    = 1'b0;
      abort         = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start || auto_pend_q) begin
               state_d       = S_RD_ID;
               auto_pend_d   = 1'b0;
               stall_cnt_d   = '0;
               avm_read_d    = 1'b1;
               avm_address_d = 1'b0;
               busy_d        = 1'b1;
               done_d        = 1'b0;
               id_ok_d       = 1'b0;
               ts_ok_d       = 1'b0;
               pass_d        = 1'b0;
               timeout_d     = 1'b0;
            end
         end
         S_RD_ID: begin
            if (avm_waitrequest) begin
               if (stall_expired) abort = 1'b1;
               else               stall_cnt_d = stall_cnt_q + 16'd1;
            end else if (READ_LATENCY == 0) begin
               capture_id = 1'b1;
            end else begin
               state_d    = S_LAT_ID;
               avm_read_d = 1'b0;
               lat_cnt_d  = '0;
            end
         end
         S_LAT_ID: begin
            if (lat_last) capture_id = 1'b1;
            else          lat_cnt_d  = lat_cnt_q + 3'd1;
         end
         S_RD_TS: begin
            if (avm_waitrequest) begin
               if (stall_expired) abort = 1'b1;
               else               stall_cnt_d = stall_cnt_q + 16'd1;
            end else if (READ_LATENCY == 0) begin
               capture_ts = 1'b1;
            end else begin
               state_d    = S_LAT_TS;
               avm_read_d = 1'b0;
               lat_cnt_d  = '0;
            end
         end
         S_LAT_TS: begin
            if (lat_last) capture_ts = 1'b1;
            else          lat_cnt_d  = lat_cnt_q + 3'd1;
         end
         default: state_d = S_IDLE;
      endcase

      if (capture_id) begin
         id_value_d    = avm_readdata;
         state_d       = S_RD_TS;
         stall_cnt_d   = '0;
         avm_read_d    = 1'b1;
         avm_address_d = 1'b1;
      end

      // The ID word is already registered; the timestamp is compared as it arrives.
      if (capture_ts) begin
         ts_value_d = avm_readdata;
         state_d    = S_DONE;
         avm_read_d = 1'b0;
         busy_d     = 1'b0;
         done_d     = 1'b1;
         id_ok_d    = (id_value_q == EXPECTED_ID);
         ts_ok_d    = (avm_readdata == EXPECTED_TIMESTAMP);
         pass_d     = id_ok_d && ts_ok_d;
      end

      if (abort) begin
         state_d    = S_DONE;
         avm_read_d = 1'b0;
         busy_d     = 1'b0;
         done_d     = 1'b1;
         timeout_d  = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         state_q       <= S_IDLE;
         auto_pend_q   <= AUTO_START;
         stall_cnt_q   <= '0;
         lat_cnt_q     <= '0;
         avm_read_q    <= 1'b0;
         avm_address_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         pass_q        <= 1'b0;
         timeout_q     <= 1'b0;
         id_value_q    <= '0;
         ts_value_q    <= '0;
      end else begin
         state_q       <= state_d;
         auto_pend_q   <= auto_pend_d;
         stall_cnt_q   <= stall_cnt_d;
         lat_cnt_q     <= lat_cnt_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         pass_q        <= pass_d;
         timeout_q     <= timeout_d;
         id_value_q    <= id_value_d;
         ts_value_q    <= ts_value_d;
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign pass        = pass_q;
   assign timeout     = timeout_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two instances (latency 0 and latency 2) against scripted sysid slaves,
// a per-cycle expected-output timeline built from the access-cost rules, and literal spot checks.
module tb_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1579770612;
   localparam int          TMO    = 4;
   localparam int          MAXC   = 400;
   localparam logic [31:0] JUNK   = 32'hBAD0_BAD0;

   typedef struct packed {
      logic        read;
      logic        addr;
      logic        busy;
      logic        done;
      logic        id_ok;
      logic        ts_ok;
      logic        pass;
      logic        timeout;
      logic [31:0] id_value;
      logic [31:0] ts_value;
   } obs_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   logic start   = 1'b0;

   logic [1:0]  av_read, av_addr, av_wr;
   logic [1:0]  o_busy, o_done, o_idok, o_tsok, o_pass, o_to;
   logic [31:0] av_rdata [2];
   logic [31:0] o_idv [2];
   logic [31:0] o_tsv [2];

   int cyc   = 0;
   int n_vec = 0;
   int n_err = 0;

   // slave script per instance
   int          slv_stall [2];
   logic [31:0] slv_id    [2];
   logic [31:0] slv_ts    [2];
   int          held      [2];
   logic        prev_rd [2], prev_wr [2], prev_ad [2];
   logic        p0v [2], p0a [2], p1v [2], p1a [2];

   obs_t exp_tab [2][MAXC];

   sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(TMO)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(av_addr[0]), .avm_read(av_read[0]),
      .avm_readdata(av_rdata[0]), .avm_waitrequest(av_wr[0]),
      .busy(o_busy[0]), .done(o_done[0]), .id_ok(o_idok[0]), .ts_ok(o_tsok[0]),
      .pass(o_pass[0]), .timeout(o_to[0]), .id_value(o_idv[0]), .ts_value(o_tsv[0])
   );

   sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(TMO)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(av_addr[1]), .avm_read(av_read[1]),
      .avm_readdata(av_rdata[1]), .avm_waitrequest(av_wr[1]),
      .busy(o_busy[1]), .done(o_done[1]), .id_ok(o_idok[1]), .ts_ok(o_tsok[1]),
      .pass(o_pass[1]), .timeout(o_to[1]), .id_value(o_idv[1]), .ts_value(o_tsv[1])
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] slv_word(input int i, input logic a);
      return a ? slv_ts[i] : slv_id[i];
   endfunction

   // Slave: stalls each access slv_stall cycles; data is only valid in the cycle it is due.
   always @(posedge clock) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            held[i] = 0;
            p0v[i] = 1'b0; p0a[i] = 1'b0; p1v[i] = 1'b0; p1a[i] = 1'b0;
         end else begin
            held[i] = (prev_rd[i] && prev_wr[i]) ? held[i] + 1 : 0;
            p1v[i]  = p0v[i];
            p1a[i]  = p0a[i];
            p0v[i]  = prev_rd[i] && !prev_wr[i];
            p0a[i]  = prev_ad[i];
         end
         av_wr[i] = av_read[i] && (held[i] < slv_stall[i]);
         if (i == 0) av_rdata[0] = (av_read[0] && !av_wr[0]) ? slv_word(0, av_addr[0]) : JUNK;
         else        av_rdata[1] = p1v[1] ? slv_word(1, p1a[1]) : JUNK;
         prev_rd[i] = av_read[i];
         prev_wr[i] = av_wr[i];
         prev_ad[i] = av_addr[i];
      end
   end

   // Model: a check accepted in cycle a costs (stalls + 1 + latency) per access, results from the cycle after.
   function automatic void model_launch(input int i, input int a);
      int          lat, s, b1, d;
      bit          to;
      obs_t        base, e;
      logic [31:0] id_new, ts_new;
      lat    = (i == 0) ? 0 : 2;
      s      = slv_stall[i];
      to     = (s >= TMO);
      base   = exp_tab[i][a];
      id_new = slv_id[i];
      ts_new = slv_ts[i];
      b1     = a + 1 + s + lat + 1;
      d      = to ? a + 1 + TMO : b1 + s + lat + 1;
      for (int k = a + 1; k < MAXC; k++) begin
         e         = base;
         e.done    = 1'b0;
         e.id_ok   = 1'b0;
         e.ts_ok   = 1'b0;
         e.pass    = 1'b0;
         e.timeout = 1'b0;
         e.busy    = (k < d);
         if (to) e.read = (k < d);
         else    e.read = (k <= a + 1 + s) || (k >= b1 && k <= b1 + s);
         e.addr = !to && (k >= b1);
         if (!to && k >= b1) e.id_value = id_new;
         if (k >= d) begin
            e.done    = 1'b1;
            e.timeout = to;
            if (!to) begin
               e.ts_value = ts_new;
               e.id_ok    = (id_new == EXP_ID);
               e.ts_ok    = (ts_new == EXP_TS);
               e.pass     = e.id_ok && e.ts_ok;
            end
         end
         exp_tab[i][k] = e;
      end
   endfunction

   function automatic void model_start(input int c);
      for (int i = 0; i < 2; i++)
         if (!exp_tab[i][c].busy) model_launch(i, c);
   endfunction

   function automatic void model_reset(input int c);
      for (int i = 0; i < 2; i++)
         for (int k = c; k < MAXC; k++) exp_tab[i][k] = '0;
   endfunction

   // Every cycle, both instances against the model timeline.
   always @(negedge clock) begin
      if (cyc >= 1 && cyc < MAXC) begin
         for (int i = 0; i < 2; i++) begin
            obs_t got;
            got.read     = av_read[i];
            got.addr     = av_addr[i];
            got.busy     = o_busy[i];
            got.done     = o_done[i];
            got.id_ok    = o_idok[i];
            got.ts_ok    = o_tsok[i];
            got.pass     = o_pass[i];
            got.timeout  = o_to[i];
            got.id_value = o_idv[i];
            got.ts_value = o_tsv[i];
            n_vec++;
            if (got !== exp_tab[i][cyc]) begin
               n_err++;
               $display("FAIL trace dut%0d cyc %0d: got rd,ad,busy,done,idok,tsok,pass,to=%b id=%h ts=%h; want %b id=%h ts=%h",
                        i, cyc, got[71:64], got.id_value, got.ts_value,
                        exp_tab[i][cyc][71:64], exp_tab[i][cyc].id_value, exp_tab[i][cyc].ts_value);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic drive_cyc(input int n);
      while (cyc < n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic at_cycle(input int n);
      do @(negedge clock); while (cyc < n);
   endtask

   task automatic pulse_start(input int c);
      drive_cyc(c);
      start = 1'b1;
      model_start(c);
      drive_cyc(c + 1);
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < MAXC; k++) exp_tab[i][k] = '0;
         slv_id[i]  = EXP_ID;
         slv_ts[i]  = EXP_TS;
         held[i]    = 0;
         prev_rd[i] = 1'b0; prev_wr[i] = 1'b0; prev_ad[i] = 1'b0;
         p0v[i] = 1'b0; p0a[i] = 1'b0; p1v[i] = 1'b0; p1a[i] = 1'b0;
         av_rdata[i] = JUNK;
      end
      av_wr        = 2'b00;
      slv_stall[0] = 0;
      slv_stall[1] = 3;
      #1 reset_n = 1'b0;

      // Auto check after reset release: dut0 zero-wait, dut1 three stalls and latency 2.
      drive_cyc(3);
      reset_n = 1'b1;
      model_launch(0, 3);
      model_launch(1, 3);
      check("model_d1_pass_c15", 32'(exp_tab[1][15].pass), 32'd0);
      check("model_d1_pass_c16", 32'(exp_tab[1][16].pass), 32'd1);
      at_cycle(4);
      check("d0_read_c4", 32'(av_read[0]), 32'd1);
      check("d0_addr_c4", 32'(av_addr[0]), 32'd0);
      at_cycle(5);
      check("d0_addr_c5", 32'(av_addr[0]), 32'd1);
      check("d0_pass_c5", 32'(o_pass[0]), 32'd0);
      at_cycle(6);
      check("d0_pass_c6", 32'(o_pass[0]), 32'd1);
      check("d0_done_c6", 32'(o_done[0]), 32'd1);
      check("d0_read_c6", 32'(av_read[0]), 32'd0);
      at_cycle(15);
      check("d1_pass_c15", 32'(o_pass[1]), 32'd0);
      at_cycle(16);
      check("d1_pass_c16", 32'(o_pass[1]), 32'd1);

      // Wrong ID word.
      drive_cyc(20);
      slv_id[0] = 32'h0000_0001;
      slv_id[1] = 32'h0000_0001;
      pulse_start(20);
      at_cycle(34);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("d%0d_badid_idv", i), o_idv[i], 32'h0000_0001);
         check($sformatf("d%0d_badid_idok", i), 32'(o_idok[i]), 32'd0);
         check($sformatf("d%0d_badid_tsok", i), 32'(o_tsok[i]), 32'd1);
         check($sformatf("d%0d_badid_pass", i), 32'(o_pass[i]), 32'd0);
      end

      // Start while busy (and on the completing cycle of dut0) is ignored; from DONE it reruns.
      drive_cyc(40);
      slv_id[0] = EXP_ID;
      slv_id[1] = EXP_ID;
      pulse_start(40);
      pulse_start(42);
      pulse_start(43);
      at_cycle(44);
      check("d0_rerun_done_c44", 32'(o_done[0]), 32'd0);
      check("d0_rerun_busy_c44", 32'(o_busy[0]), 32'd1);
      pulse_start(60);

      // Stuck waitrequest: abort after TMO stalls, no timestamp read.
      drive_cyc(80);
      slv_stall[0] = 255;
      slv_stall[1] = 255;
      pulse_start(80);
      at_cycle(86);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("d%0d_stuck_to", i), 32'(o_to[i]), 32'd1);
         check($sformatf("d%0d_stuck_done", i), 32'(o_done[i]), 32'd1);
         check($sformatf("d%0d_stuck_pass", i), 32'(o_pass[i]), 32'd0);
         check($sformatf("d%0d_stuck_ts", i), o_tsv[i], EXP_TS);
      end

      // Reset during dut1's timestamp latency wait, then a fresh auto check.
      drive_cyc(90);
      slv_stall[0] = 0;
      slv_stall[1] = 3;
      pulse_start(95);
      drive_cyc(106);
      reset_n = 1'b0;
      model_reset(106);
      at_cycle(106);
      check("d1_rst_ts", o_tsv[1], 32'd0);
      check("d1_rst_done", 32'(o_done[1]), 32'd0);
      drive_cyc(108);
      reset_n = 1'b1;
      model_launch(0, 108);
      model_launch(1, 108);
      at_cycle(122);
      check("d0_after_rst_pass", 32'(o_pass[0]), 32'd1);
      check("d1_after_rst_pass", 32'(o_pass[1]), 32'd1);

      drive_cyc(130);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
